// File: rtl/fifo_rd_deserializer.sv
// Pops serial bits from the FIFO read port and assembles them LSB-first into words
// behind a one-word valid/ready output register. Optional parity: FIFO_RD_DESER_PARITY_EN.
module fifo_rd_deserializer #(
    parameter int WORD_WIDTH = 8,
    parameter int CNT_WIDTH  = 4
) (
    input  logic                  i_Clk,
    input  logic                  i_Rst,
    input  logic                  i_Data_In,
    input  logic                  i_empty,
    output logic                  o_R_en,
    output logic [WORD_WIDTH-1:0] o_Word,
    output logic                  o_Valid,
    input  logic                  i_Ready,
    output logic                  o_Parity_Err,
    output logic [15:0]           o_Word_Cnt
);

`ifdef FIFO_RD_DESER_PARITY_EN
    localparam int FRAME_LEN = WORD_WIDTH + 1;
`else
    localparam int FRAME_LEN = WORD_WIDTH;
`endif
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(FRAME_LEN - 1);

    logic [CNT_WIDTH-1:0]  bit_cnt_q, bit_cnt_d;
    logic [WORD_WIDTH-1:0] shift_q, shift_d;
    logic [WORD_WIDTH-1:0] word_q;
    logic                  valid_q;
    logic [15:0]           word_cnt_q;
    logic                  last_bit, stall, pop, complete, accept;

    assign last_bit = (bit_cnt_q == LAST_CNT);
    // Only the completing pop waits for the output register; earlier bits keep flowing.
    assign stall    = last_bit & valid_q & ~i_Ready;
    assign o_R_en   = ~i_Rst & ~stall;
    assign pop      = o_R_en & ~i_empty;
    assign complete = pop & last_bit;
    assign accept   = valid_q & i_Ready;

    assign bit_cnt_d = complete ? '0 : (pop ? bit_cnt_q + CNT_WIDTH'(1) : bit_cnt_q);

    // The parity slot (bit_cnt == WORD_WIDTH) matches no data position, so it never lands here.
    for (genvar gi = 0; gi < WORD_WIDTH; gi++) begin : g_shift
        assign shift_d[gi] = (pop && bit_cnt_q == CNT_WIDTH'(gi)) ? i_Data_In : shift_q[gi];
    end

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            bit_cnt_q  <= '0;
            shift_q    <= '0;
            word_q     <= '0;
            valid_q    <= 1'b0;
            word_cnt_q <= '0;
        end else begin
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            if (complete) begin
                word_q  <= shift_d;
                valid_q <= 1'b1;
            end else if (accept) begin
                valid_q <= 1'b0;
            end
            if (accept && word_cnt_q != 16'hFFFF) begin
                word_cnt_q <= word_cnt_q + 16'd1;
            end
        end
    end

`ifdef FIFO_RD_DESER_PARITY_EN
    logic perr_q;

    always_ff @(posedge i_Clk) begin
        if (i_Rst) begin
            perr_q <= 1'b0;
        end else if (complete) begin
            // Data bits are all stored by now; the live input is the parity bit.
            perr_q <= (^shift_q) ^ i_Data_In;
        end
    end

    assign o_Parity_Err = perr_q;
`else
    assign o_Parity_Err = 1'b0;
`endif

    assign o_Word     = word_q;
    assign o_Valid    = valid_q;
    assign o_Word_Cnt = word_cnt_q;

endmodule

// File: tb/tb_fifo_rd_deserializer.sv
// Bench for fifo_rd_deserializer: a bit-queue FIFO model feeds the DUT and a word
// scoreboard checks every accepted output word.
module tb_fifo_rd_deserializer;

    localparam int W = 8;
`ifdef FIFO_RD_DESER_PARITY_EN
    localparam int FL = W + 1;
`else
    localparam int FL = W;
`endif

    typedef struct packed {
        logic [W-1:0] w;
        logic         p;
    } exp_t;

    logic         clk = 1'b0;
    logic         i_Rst = 1'b1;
    logic         i_Data_In = 1'b0;
    logic         i_empty = 1'b1;
    logic         o_R_en;
    logic [W-1:0] o_Word;
    logic         o_Valid;
    logic         i_Ready = 1'b0;
    logic         o_Parity_Err;
    logic [15:0]  o_Word_Cnt;

    bit   bitq[$];
    exp_t exp_q[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   pops = 0;
    int   gap_len = 0;
    int   gap_left = 0;
    int   valid_cycles = 0;

    fifo_rd_deserializer #(.WORD_WIDTH(W), .CNT_WIDTH(4)) dut (
        .i_Clk(clk),
        .i_Rst(i_Rst),
        .i_Data_In(i_Data_In),
        .i_empty(i_empty),
        .o_R_en(o_R_en),
        .o_Word(o_Word),
        .o_Valid(o_Valid),
        .i_Ready(i_Ready),
        .o_Parity_Err(o_Parity_Err),
        .o_Word_Cnt(o_Word_Cnt)
    );

    always #5 clk = ~clk;

    task automatic push_frame(input logic [W-1:0] w, input logic par);
        exp_t e;
        for (int i = 0; i < W; i++) bitq.push_back(w[i]);
`ifdef FIFO_RD_DESER_PARITY_EN
        bitq.push_back(par);
        e.p = (^w) ^ par;
`else
        e.p = 1'b0;
`endif
        e.w = w;
        exp_q.push_back(e);
    endtask

    task automatic push_word(input logic [W-1:0] w);
        push_frame(w, ^w);
    endtask

    // One clock: drive FIFO model at negedge, compare any accept, retire a pop after the edge.
    task automatic cycle();
        bit   will_pop;
        exp_t e;
        @(negedge clk);
        if (gap_left > 0 || bitq.size() == 0) begin
            i_empty   = 1'b1;
            i_Data_In = 1'b0;
        end else begin
            i_empty   = 1'b0;
            i_Data_In = bitq[0];
        end
        #1;
        will_pop = (o_R_en === 1'b1) && !i_empty;
        if (o_Valid === 1'b1) valid_cycles++;
        if (o_Valid === 1'b1 && i_Ready && !i_Rst) begin
            n_tests++;
            if (exp_q.size() == 0) begin
                n_fail++;
                $display("[TB] FAIL scoreboard_extra: got word=%h perr=%b, required no output", o_Word, o_Parity_Err);
            end else begin
                e = exp_q.pop_front();
                if (o_Word !== e.w || o_Parity_Err !== e.p) begin
                    n_fail++;
                    $display("[TB] FAIL scoreboard_word: got word=%h perr=%b, required word=%h perr=%b",
                             o_Word, o_Parity_Err, e.w, e.p);
                end else begin
                    $display("[TB] accept word=%h perr=%b", o_Word, o_Parity_Err);
                end
            end
        end
        if (gap_left > 0) gap_left--;
        @(posedge clk);
        #1;
        if (will_pop) begin
            void'(bitq.pop_front());
            pops++;
            gap_left = gap_len;
        end
    endtask

    task automatic run_drain(input int bound);
        int k = 0;
        while ((exp_q.size() != 0 || bitq.size() != 0) && k < bound) begin
            cycle();
            k++;
        end
        if (exp_q.size() != 0 || bitq.size() != 0) begin
            n_tests++;
            n_fail++;
            $display("[TB] FAIL drain_timeout: %0d words and %0d bits left after %0d cycles, required 0",
                     exp_q.size(), bitq.size(), bound);
            exp_q.delete();
            bitq.delete();
        end
    endtask

    task automatic test_reset();
        i_Rst = 1'b1;
        for (int i = 0; i < FL; i++) bitq.push_back(1'b1);
        pops = 0;
        repeat (3) cycle();
        n_tests++;
        if (o_R_en !== 1'b0 || o_Valid !== 1'b0 || o_Word !== '0 || o_Word_Cnt !== 16'd0) begin
            n_fail++;
            $display("[TB] FAIL reset_state: got ren=%b valid=%b word=%h cnt=%0d, required 0/0/00/0",
                     o_R_en, o_Valid, o_Word, o_Word_Cnt);
        end
        n_tests++;
        if (pops != 0) begin
            n_fail++;
            $display("[TB] FAIL reset_no_pop: got %0d pops, required 0", pops);
        end
        bitq.delete();
        i_Rst = 1'b0;
        cycle();
        n_tests++;
        if (o_R_en !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL reset_release_ren: got %b, required 1", o_R_en);
        end
    endtask

    task automatic test_basic();
        i_Ready = 1'b1;
        valid_cycles = 0;
        push_word(8'hA5);
        run_drain(60);
        n_tests++;
        if (o_Valid !== 1'b0 || valid_cycles != 1) begin
            n_fail++;
            $display("[TB] FAIL basic_valid_pulse: got valid=%b cycles=%0d, required 0 and 1", o_Valid, valid_cycles);
        end
        n_tests++;
        if (o_Word_Cnt !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL basic_count: got %0d, required 1", o_Word_Cnt);
        end
    endtask

    task automatic test_back_pressure();
        i_Ready = 1'b0;
        pops = 0;
        push_word(8'h3C);
        push_word(8'hF0);
        repeat (3 * FL) cycle();
        n_tests++;
        if (o_Valid !== 1'b1 || o_Word !== 8'h3C) begin
            n_fail++;
            $display("[TB] FAIL bp_hold: got valid=%b word=%h, required 1 and 3c", o_Valid, o_Word);
        end
        n_tests++;
        if (o_R_en !== 1'b0 || pops != 2 * FL - 1 || bitq.size() != 1) begin
            n_fail++;
            $display("[TB] FAIL bp_stall: got ren=%b pops=%0d left=%0d, required 0, %0d, 1",
                     o_R_en, pops, bitq.size(), 2 * FL - 1);
        end
        i_Ready = 1'b1;
        run_drain(40);
        n_tests++;
        if (o_Word_Cnt !== 16'd3) begin
            n_fail++;
            $display("[TB] FAIL bp_count: got %0d, required 3", o_Word_Cnt);
        end
    endtask

    task automatic test_back_to_back();
        int k = 0;
        i_Ready = 1'b1;
        valid_cycles = 0;
        push_word(8'h12);
        push_word(8'h34);
        push_word(8'hC7);
        while (bitq.size() != 0 && k < 100) begin
            cycle();
            k++;
        end
        // After the final completing pop the last word is the only one still owed.
        n_tests++;
        if (exp_q.size() != 1 || o_Valid !== 1'b1) begin
            n_fail++;
            $display("[TB] FAIL b2b_pending: got pending=%0d valid=%b, required 1 and 1", exp_q.size(), o_Valid);
        end
        run_drain(10);
        n_tests++;
        if (valid_cycles != 3 || o_Word_Cnt !== 16'd6) begin
            n_fail++;
            $display("[TB] FAIL b2b_throughput: got valid_cycles=%0d cnt=%0d, required 3 and 6",
                     valid_cycles, o_Word_Cnt);
        end
    endtask

    task automatic test_gaps();
        int start_pops;
        i_Ready = 1'b1;
        gap_len = 5;
        start_pops = pops;
        push_word(8'h81);
        run_drain(300);
        gap_len = 0;
        gap_left = 0;
        n_tests++;
        if (pops - start_pops != FL || o_Word_Cnt !== 16'd7) begin
            n_fail++;
            $display("[TB] FAIL gaps: got pops=%0d cnt=%0d, required %0d and 7", pops - start_pops, o_Word_Cnt, FL);
        end
    endtask

    task automatic test_reset_mid();
        i_Ready = 1'b1;
        pops = 0;
        for (int i = 0; i < 4; i++) bitq.push_back(1'b1);
        repeat (4) cycle();
        n_tests++;
        if (pops != 4) begin
            n_fail++;
            $display("[TB] FAIL midreset_prefix: got %0d pops, required 4", pops);
        end
        i_Rst = 1'b1;
        cycle();
        i_Rst = 1'b0;
        n_tests++;
        if (o_Word !== '0 || o_Word_Cnt !== 16'd0 || o_Valid !== 1'b0) begin
            n_fail++;
            $display("[TB] FAIL midreset_clear: got word=%h cnt=%0d valid=%b, required 00/0/0", o_Word, o_Word_Cnt, o_Valid);
        end
        push_word(8'h5A);
        run_drain(60);
        n_tests++;
        if (o_Word_Cnt !== 16'd1) begin
            n_fail++;
            $display("[TB] FAIL midreset_count: got %0d, required 1", o_Word_Cnt);
        end
    endtask

    task automatic test_parity();
        i_Ready = 1'b1;
        push_frame(8'h07, 1'b1);
        push_frame(8'h07, 1'b0);
        push_frame(8'hFF, 1'b1);
        run_drain(80);
        n_tests++;
        if (o_Word_Cnt !== 16'd4) begin
            n_fail++;
            $display("[TB] FAIL parity_count: got %0d, required 4", o_Word_Cnt);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_pressure();
        test_back_to_back();
        test_gaps();
        test_reset_mid();
        test_parity();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_rd_deserializer.md
Name: fifo_rd_deserializer

Overview:
Read-side consumer for the 1-bit SerDes FIFO. It pops serial bits from the FIFO read port whenever the FIFO is not empty, then assembles them LSB-first into WORD_WIDTH-bit parallel words. Each word is presented on a valid/ready output handshake with a one-word output register, so collection of the next word overlaps the wait for acceptance. It sits in the read clock domain, between the FIFO storage/empty-flag logic and the parallel receive datapath.

Parameters:
WORD_WIDTH, 8, data bits per assembled word (>=2)
CNT_WIDTH, 4, bit counter width; must satisfy 2^CNT_WIDTH > WORD_WIDTH

Ports:
i_Clk  input  1  read-domain clock; all state updates on rising edge
i_Rst  input  1  synchronous, active-high reset
i_Data_In  input  1  FIFO read data; combinational, valid whenever i_empty=0
i_empty  input  1  FIFO empty flag, read domain
o_R_en  output  1  FIFO read enable; a pop occurs on an edge where o_R_en=1 and i_empty=0
o_Word  output  WORD_WIDTH  assembled word; bit 0 = first bit popped
o_Valid  output  1  o_Word is valid
i_Ready  input  1  downstream accepts o_Word when o_Valid=1 and i_Ready=1
o_Parity_Err  output  1  parity error flag qualified by o_Valid; constant 0 unless PARITY_EN
o_Word_Cnt  output  16  count of accepted words; saturates at 0xFFFF

Behaviour:
- Reset (i_Rst=1 at an edge): bit counter=0, shift register=0, o_Word=0, o_Valid=0, o_Parity_Err=0, o_Word_Cnt=0. o_R_en is forced to 0 combinationally while i_Rst=1. Reset mid-word discards any partial word and any held output word.
- Frame length: L = WORD_WIDTH, or WORD_WIDTH+1 with PARITY_EN.
- Bit counter runs from 0 to L-1.
- Pop on an edge with o_R_en & !i_empty: sample i_Data_In into shift position bit_cnt (parity slot when bit_cnt=WORD_WIDTH), then increment bit_cnt.
- The pop at bit_cnt=L-1 is the completing pop. On that edge: the word is loaded into o_Word, o_Valid is set on the next cycle, and bit_cnt wraps to 0.
- o_R_en = !i_Rst & !(bit_cnt==L-1 & o_Valid & !i_Ready).
  - Collection continues while a word is held.
  - Only the completing pop stalls, when the output register is still occupied and not being accepted this cycle.
- Simultaneous accept and completion (o_Valid & i_Ready & completing pop on the same edge): the new word loads and o_Valid stays 1. Throughput is one word per L cycles with no bubble.
- Accept without completion: o_Valid clears on the next edge.
- o_Word and o_Parity_Err stay stable while o_Valid=1 and i_Ready=0.
- i_empty=1: no pop, state holds. Gaps of any length between bits are tolerated.
- Word counter: o_Word_Cnt increments on each edge with o_Valid & i_Ready and saturates at 0xFFFF.
- Latency: the completing pop at edge N gives o_Valid=1 after edge N.

Optional Feature:
Macro: FIFO_RD_DESER_PARITY_EN
- Defined: each frame is WORD_WIDTH data bits followed by one even-parity bit.
  - On the completing pop, o_Parity_Err <= XOR(data bits) ^ parity bit. The flag is 1 when the frame's total count of 1s is odd.
  - The parity bit is not placed in o_Word.
- Undefined: frames are WORD_WIDTH bits and o_Parity_Err is tied 0. The port still exists.

Test Plan:
1. Reset: hold i_Rst=1 for 3 cycles with FIFO non-empty -> o_R_en=0, o_Valid=0, o_Word=0, o_Word_Cnt=0, no pops.
2. Basic word: WORD_WIDTH=8, i_Ready=1, FIFO supplies bits 1,0,1,0,0,1,0,1 with no gaps -> o_Word=0xA5 with o_Valid=1 for one cycle after the 8th pop; o_Word_Cnt=1.
3. Back-pressure: i_Ready=0, stream 0x3C then 0xF0 -> 0x3C held; o_R_en drops at bit_cnt=7; exactly 7 bits of 0xF0 are popped. Raise i_Ready -> 0x3C accepted, the 8th bit pops, 0xF0 presents; o_Word_Cnt increments per accept.
4. Empty gaps: insert 5-cycle i_empty=1 gaps between every bit of 0x81 -> o_Word=0x81; no pops during gaps.
5. Reset mid-word: pop 4 bits, pulse i_Rst for 1 cycle, then stream 0x5A -> o_Word=0x5A; earlier partial bits lost.
6. Parity (PARITY_EN): frame 0x07 + parity 1 -> o_Parity_Err=0. Frame 0x07 + parity 0 -> o_Parity_Err=1 and o_Word=0x07.
